// File: rtl/idu_is_biq_ctrl_if.sv
// rtl/idu_is_biq_ctrl_if.sv - BIQ controller bus: dispatch, entry, RF-stage and flush/stall signals
interface idu_is_biq_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
);
    logic             rtu_global_flush;
    logic             dis_biq_vld;
    logic             biq_dis_full;
    logic [DEPTH-1:0] entry_vld;
    logic [DEPTH-1:0] entry_ready;
    logic [DEPTH-1:0] entry_create_vld;
    logic [DEPTH-1:0] entry_issue_vld;
    logic             exu_biq_stall;
    logic             biq_rf_vld;
    logic [IDX_W-1:0] biq_rf_idx;
    logic [IDX_W:0]   biq_cnt;

    modport master (
        input  rtu_global_flush, dis_biq_vld, entry_vld, entry_ready, exu_biq_stall,
        output biq_dis_full, entry_create_vld, entry_issue_vld, biq_rf_vld, biq_rf_idx, biq_cnt
    );

    modport slave (
        output rtu_global_flush, dis_biq_vld, entry_vld, entry_ready, exu_biq_stall,
        input  biq_dis_full, entry_create_vld, entry_issue_vld, biq_rf_vld, biq_rf_idx, biq_cnt
    );
endinterface

// File: rtl/idu_is_biq_ctrl.sv
// rtl/idu_is_biq_ctrl.sv - branch issue queue controller: free-slot create, age-matrix oldest-ready issue
module idu_is_biq_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst_clk,
    idu_is_biq_ctrl_if.master   bus
);
    localparam int CNT_W = IDX_W + 1;

    // age[i][j] set means entry j is older than entry i
    logic [DEPTH-1:0] age     [DEPTH];
    logic [DEPTH-1:0] age_nxt [DEPTH];

    logic             full;
    logic             create_ok;
    logic             issue_ok;
    logic             found;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] win_oh;
    logic [IDX_W-1:0] win_idx;
    logic [DEPTH-1:0] create_vld;
    logic [DEPTH-1:0] issue_vld;

    logic             rf_vld_q;
    logic [IDX_W-1:0] rf_idx_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        full      = &bus.entry_vld;
        create_ok = bus.dis_biq_vld & ~full & ~bus.rtu_global_flush;

        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!bus.entry_vld[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end

        cand    = bus.entry_vld & bus.entry_ready;
        win_oh  = '0;
        win_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && ((cand & age[i]) == '0)) begin
                win_oh[i] = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        issue_ok = (|cand) & ~bus.exu_biq_stall & ~bus.rtu_global_flush;

        create_vld = create_ok ? free_oh : '0;
        issue_vld  = issue_ok  ? win_oh  : '0;
    end

    // Row updates first, then clear the columns of every created or issued slot
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_nxt[i] = age[i];
            if (create_vld[i]) age_nxt[i] = bus.entry_vld & ~issue_vld;
            if (issue_vld[i])  age_nxt[i] = '0;
            age_nxt[i] = age_nxt[i] & ~(create_vld | issue_vld);
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            age      <= '{default: '0};
            rf_vld_q <= 1'b0;
            rf_idx_q <= '0;
            cnt_q    <= '0;
        end else if (bus.rtu_global_flush) begin
            age      <= '{default: '0};
            rf_vld_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            age      <= age_nxt;
            rf_vld_q <= issue_ok;
            if (issue_ok) rf_idx_q <= win_idx;
            cnt_q    <= cnt_q + CNT_W'(create_ok) - CNT_W'(issue_ok);
        end
    end

    assign bus.biq_dis_full     = full;
    assign bus.entry_create_vld = create_vld;
    assign bus.entry_issue_vld  = issue_vld;
    assign bus.biq_rf_vld       = rf_vld_q;
    assign bus.biq_rf_idx       = rf_idx_q;
    assign bus.biq_cnt          = cnt_q;
endmodule

// File: tb/tb_idu_is_biq_ctrl.sv
// tb/tb_idu_is_biq_ctrl.sv - directed-vector bench for idu_is_biq_ctrl with a behavioural entry array
module tb_idu_is_biq_ctrl;
    logic clk = 1'b0;
    logic rst_clk = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    logic [3:0] ent_vld;
    logic [3:0] rdy = 4'b0000;

    idu_is_biq_ctrl_if #(.DEPTH(4), .IDX_W(2)) bus ();

    idu_is_biq_ctrl #(.DEPTH(4), .IDX_W(2)) dut (
        .clk     (clk),
        .rst_clk (rst_clk),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Entries set on create, clear on issue or flush
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) ent_vld <= '0;
        else if (bus.rtu_global_flush) ent_vld <= '0;
        else ent_vld <= (ent_vld | bus.entry_create_vld) & ~bus.entry_issue_vld;
    end

    assign bus.entry_vld   = ent_vld;
    assign bus.entry_ready = rdy;

    always @(negedge clk) begin
        if (rst_clk) begin
            vectors++;
            if (bus.biq_cnt !== 3'($countones(ent_vld))) begin
                miscompares++;
                $display("FAIL cnt_invariant: biq_cnt=%0d popcount=%0d", bus.biq_cnt, $countones(ent_vld));
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic fill(input int n);
        bus.dis_biq_vld = 1'b1;
        repeat (n) tick();
        bus.dis_biq_vld = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        rdy = 4'b1111;
        while (ent_vld != 4'b0000 && n < 8) begin
            tick();
            n++;
        end
        rdy = 4'b0000;
        vectors++;
        if (ent_vld !== 4'b0000) begin
            miscompares++;
            $display("FAIL drain_timeout: ent_vld=%b want 0000", ent_vld);
        end
    endtask

    task automatic test_reset;
        bus.rtu_global_flush = 1'b0;
        bus.dis_biq_vld      = 1'b0;
        bus.exu_biq_stall    = 1'b0;
        rst_clk = 1'b0;
        repeat (2) tick();
        #1;
        vectors++;
        if (bus.biq_rf_vld !== 1'b0 || bus.biq_rf_idx !== 2'd0 || bus.biq_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_regs: rf_vld=%b rf_idx=%0d cnt=%0d want 0 0 0", bus.biq_rf_vld, bus.biq_rf_idx, bus.biq_cnt);
        end
        vectors++;
        if (bus.biq_dis_full !== 1'b0 || bus.entry_create_vld !== 4'b0000 || bus.entry_issue_vld !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_comb: full=%b create=%b issue=%b want 0 0000 0000", bus.biq_dis_full, bus.entry_create_vld, bus.entry_issue_vld);
        end
        tick();
        rst_clk = 1'b1;
        tick();
    endtask

    task automatic test_fill;
        logic [3:0] exp;
        bus.dis_biq_vld = 1'b1;
        rdy = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            exp = 4'b0001 << k;
            #1;
            vectors++;
            if (bus.entry_create_vld !== exp || bus.biq_dis_full !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_create%0d: create=%b full=%b want %b 0", k, bus.entry_create_vld, bus.biq_dis_full, exp);
            end
            tick();
        end
        #1;
        vectors++;
        if (bus.biq_cnt !== 3'd4 || bus.biq_dis_full !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: cnt=%0d full=%b want 4 1", bus.biq_cnt, bus.biq_dis_full);
        end
        vectors++;
        if (bus.entry_create_vld !== 4'b0000) begin
            miscompares++;
            $display("FAIL fill_fifth: create=%b want 0000", bus.entry_create_vld);
        end
        tick();
        bus.dis_biq_vld = 1'b0;
    endtask

    task automatic test_in_order_issue;
        logic [3:0] exp;
        rdy = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp = 4'b0001 << k;
            #1;
            vectors++;
            if (bus.entry_issue_vld !== exp) begin
                miscompares++;
                $display("FAIL order_issue%0d: issue=%b want %b", k, bus.entry_issue_vld, exp);
            end
            tick();
            vectors++;
            if (bus.biq_rf_vld !== 1'b1 || bus.biq_rf_idx !== 2'(k)) begin
                miscompares++;
                $display("FAIL order_rf%0d: rf_vld=%b rf_idx=%0d want 1 %0d", k, bus.biq_rf_vld, bus.biq_rf_idx, k);
            end
        end
        vectors++;
        if (bus.biq_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL order_cnt: cnt=%0d want 0", bus.biq_cnt);
        end
        tick();
        vectors++;
        if (bus.biq_rf_vld !== 1'b0 || bus.biq_rf_idx !== 2'd3) begin
            miscompares++;
            $display("FAIL order_idle: rf_vld=%b rf_idx=%0d want 0 3", bus.biq_rf_vld, bus.biq_rf_idx);
        end
        rdy = 4'b0000;
    endtask

    task automatic test_age_reuse;
        fill(4);
        rdy = 4'b0010;
        #1;
        vectors++;
        if (bus.entry_issue_vld !== 4'b0010) begin
            miscompares++;
            $display("FAIL reuse_issue1: issue=%b want 0010", bus.entry_issue_vld);
        end
        tick();
        rdy = 4'b0000;
        bus.dis_biq_vld = 1'b1;
        #1;
        vectors++;
        if (bus.entry_create_vld !== 4'b0010) begin
            miscompares++;
            $display("FAIL reuse_create1: create=%b want 0010", bus.entry_create_vld);
        end
        tick();
        bus.dis_biq_vld = 1'b0;
        rdy = 4'b1010;
        #1;
        vectors++;
        if (bus.entry_issue_vld !== 4'b1000) begin
            miscompares++;
            $display("FAIL reuse_old3: issue=%b want 1000", bus.entry_issue_vld);
        end
        tick();
        #1;
        vectors++;
        if (bus.entry_issue_vld !== 4'b0010 || bus.biq_rf_idx !== 2'd3) begin
            miscompares++;
            $display("FAIL reuse_new1: issue=%b rf_idx=%0d want 0010 3", bus.entry_issue_vld, bus.biq_rf_idx);
        end
        tick();
        vectors++;
        if (bus.biq_rf_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL reuse_rf1: rf_idx=%0d want 1", bus.biq_rf_idx);
        end
        rdy = 4'b0000;
        drain();
    endtask

    task automatic test_stall;
        fill(4);
        rdy = 4'b0100;
        bus.exu_biq_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (bus.entry_issue_vld !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_issue%0d: issue=%b want 0000", k, bus.entry_issue_vld);
            end
            tick();
            vectors++;
            if (bus.biq_rf_vld !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_rf%0d: rf_vld=%b want 0", k, bus.biq_rf_vld);
            end
        end
        bus.exu_biq_stall = 1'b0;
        #1;
        vectors++;
        if (bus.entry_issue_vld !== 4'b0100) begin
            miscompares++;
            $display("FAIL stall_release: issue=%b want 0100", bus.entry_issue_vld);
        end
        tick();
        vectors++;
        if (bus.biq_rf_vld !== 1'b1 || bus.biq_rf_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL stall_rf_after: rf_vld=%b rf_idx=%0d want 1 2", bus.biq_rf_vld, bus.biq_rf_idx);
        end
        rdy = 4'b0000;
        drain();
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp;
        fill(3);
        bus.dis_biq_vld = 1'b1;
        rdy = 4'b0001;
        #1;
        vectors++;
        if (bus.entry_create_vld !== 4'b1000 || bus.entry_issue_vld !== 4'b0001) begin
            miscompares++;
            $display("FAIL b2b_strobes: create=%b issue=%b want 1000 0001", bus.entry_create_vld, bus.entry_issue_vld);
        end
        tick();
        bus.dis_biq_vld = 1'b0;
        rdy = 4'b0000;
        vectors++;
        if (bus.biq_cnt !== 3'd3) begin
            miscompares++;
            $display("FAIL b2b_cnt: cnt=%0d want 3", bus.biq_cnt);
        end
        rdy = 4'b1111;
        for (int k = 1; k < 4; k++) begin
            exp = 4'b0001 << k;
            #1;
            vectors++;
            if (bus.entry_issue_vld !== exp) begin
                miscompares++;
                $display("FAIL b2b_order%0d: issue=%b want %b", k, bus.entry_issue_vld, exp);
            end
            tick();
        end
        rdy = 4'b0000;
    endtask

    task automatic test_flush;
        fill(3);
        rdy = 4'b0001;
        tick();
        bus.rtu_global_flush = 1'b1;
        bus.dis_biq_vld = 1'b1;
        rdy = 4'b0010;
        #1;
        vectors++;
        if (bus.entry_create_vld !== 4'b0000 || bus.entry_issue_vld !== 4'b0000) begin
            miscompares++;
            $display("FAIL flush_strobes: create=%b issue=%b want 0000 0000", bus.entry_create_vld, bus.entry_issue_vld);
        end
        tick();
        bus.rtu_global_flush = 1'b0;
        bus.dis_biq_vld = 1'b0;
        rdy = 4'b0000;
        vectors++;
        if (bus.biq_cnt !== 3'd0 || bus.biq_rf_vld !== 1'b0 || ent_vld !== 4'b0000) begin
            miscompares++;
            $display("FAIL flush_after: cnt=%0d rf_vld=%b ent=%b want 0 0 0000", bus.biq_cnt, bus.biq_rf_vld, ent_vld);
        end
        fill(4);
        rdy = 4'b1111;
        #1;
        vectors++;
        if (bus.entry_issue_vld !== 4'b0001) begin
            miscompares++;
            $display("FAIL flush_refill_order: issue=%b want 0001", bus.entry_issue_vld);
        end
        drain();
    endtask

    task automatic test_reset_mid;
        fill(2);
        rdy = 4'b0010;
        tick();
        rdy = 4'b0000;
        vectors++;
        if (bus.biq_rf_vld !== 1'b1 || bus.biq_rf_idx !== 2'd1 || bus.biq_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL midrst_pre: rf_vld=%b rf_idx=%0d cnt=%0d want 1 1 1", bus.biq_rf_vld, bus.biq_rf_idx, bus.biq_cnt);
        end
        rst_clk = 1'b0;
        #1;
        vectors++;
        if (bus.biq_rf_vld !== 1'b0 || bus.biq_rf_idx !== 2'd0 || bus.biq_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL midrst_regs: rf_vld=%b rf_idx=%0d cnt=%0d want 0 0 0", bus.biq_rf_vld, bus.biq_rf_idx, bus.biq_cnt);
        end
        vectors++;
        if (bus.biq_dis_full !== 1'b0 || bus.entry_issue_vld !== 4'b0000 || bus.entry_create_vld !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_comb: full=%b issue=%b create=%b want 0 0000 0000", bus.biq_dis_full, bus.entry_issue_vld, bus.entry_create_vld);
        end
        repeat (2) tick();
        rst_clk = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_in_order_issue();
        test_age_reuse();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
